// File: rtl/rsa_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : rsa_decrypt
// Purpose  : Multi-cycle modular exponentiation Plain = C^d mod n.
//            C is first reduced mod n with a restoring shift-subtract divider.
//            The exponent is then scanned MSB first with square-and-multiply.
//            Each modular multiply is a 16-step interleaved shift-add-reduce.
// Ports    : Clk, Reset (sync, active-high)
//            Start                   - request, sampled only in IDLE
//            Cipher_val/Exp_key/
//            Mod_key [WIDTH-1:0]     - C, d, n (captured on Start)
//            Plain_val [WIDTH-1:0]   - result, held until next completion
//            Plain_done              - one-cycle completion pulse
//            Busy                    - high while an operation is in flight
//            Err                     - one-cycle error pulse
// Config   : RSA_DEC_MODCHECK_EN - when defined, Start with Mod_key == 0
//            goes to ERR and pulses Err together with Plain_done.
//            When undefined, Err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_decrypt #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Cipher_val,
  input  logic [WIDTH-1:0] Exp_key,
  input  logic [WIDTH-1:0] Mod_key,
  output logic [WIDTH-1:0] Plain_val,
  output logic             Plain_done,
  output logic             Busy,
  output logic             Err
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef RSA_DEC_MODCHECK_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, REDUCE = 3'd1, SQR = 3'd2, MUL = 3'd3, FINISH = 3'd4, ERR = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, REDUCE = 3'd1, SQR = 3'd2, MUL = 3'd3, FINISH = 3'd4
  } state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cipher, exponent, modulus;
  logic [WIDTH-1:0] base;   // running remainder during REDUCE, then C mod n
  logic [WIDTH-1:0] r;      // exponentiation accumulator R
  logic [WIDTH-1:0] acc;    // partial product of the current modular multiply
  logic [CW-1:0]    cnt;    // bit index within the current 16-step pass
  logic [CW-1:0]    ebit;   // exponent bit currently being processed

  // One extra bit of headroom: 2*acc and acc + x are both below 2n <= 2^17.
  logic [WIDTH:0]   mod_ext, red_try, mm_dbl, mm_add;
  logic [WIDTH-1:0] red_val, mm_val, mm_y;

  assign mod_ext = {1'b0, modulus};

  // Datapath step shared by all states; only the active state consumes it.
  always_comb begin
    red_try = {base, cipher[cnt]};
    red_val = (red_try >= mod_ext) ? WIDTH'(red_try - mod_ext) : WIDTH'(red_try);

    // SQR computes R*R, MUL computes R*base; x is always R.
    mm_y   = (state == MUL) ? base : r;
    mm_dbl = {acc, 1'b0};
    if (mm_dbl >= mod_ext) mm_dbl = mm_dbl - mod_ext;
    mm_add = mm_dbl + (mm_y[cnt] ? {1'b0, r} : {(WIDTH+1){1'b0}});
    mm_val = (mm_add >= mod_ext) ? WIDTH'(mm_add - mod_ext) : WIDTH'(mm_add);
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) begin
`ifdef RSA_DEC_MODCHECK_EN
          state_nxt = (Mod_key == '0) ? ERR : REDUCE;
`else
          state_nxt = REDUCE;
`endif
        end
      end
      REDUCE: if (cnt == '0) state_nxt = SQR;
      SQR: begin
        if (cnt == '0) begin
          if (exponent[ebit])    state_nxt = MUL;
          else if (ebit == '0)   state_nxt = FINISH;
          else                   state_nxt = SQR;
        end
      end
      MUL:    if (cnt == '0) state_nxt = (ebit == '0) ? FINISH : SQR;
      FINISH: state_nxt = IDLE;
`ifdef RSA_DEC_MODCHECK_EN
      ERR:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RSA_DEC_MODCHECK_EN
  logic err_q;
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cipher     <= '0;
      exponent   <= '0;
      modulus    <= '0;
      base       <= '0;
      r          <= '0;
      acc        <= '0;
      cnt        <= '0;
      ebit       <= '0;
      Plain_val  <= '0;
      Plain_done <= 1'b0;
      Busy       <= 1'b0;
`ifdef RSA_DEC_MODCHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      Plain_done <= 1'b0;
`ifdef RSA_DEC_MODCHECK_EN
      err_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Start) begin
            cipher   <= Cipher_val;
            exponent <= Exp_key;
            modulus  <= Mod_key;
            base     <= '0;
            acc      <= '0;
            cnt      <= LAST;
            ebit     <= LAST;
            Busy     <= 1'b1;
          end
        end
        REDUCE: begin
          base <= red_val;
          cnt  <= (cnt == '0) ? LAST : cnt - 1'b1;
          // R starts at 1, except n = 1 where every residue is 0.
          if (cnt == '0) r <= (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
        end
        SQR, MUL: begin
          acc <= mm_val;
          cnt <= (cnt == '0) ? LAST : cnt - 1'b1;
          if (cnt == '0) begin
            r   <= mm_val;
            acc <= '0;
            // A set bit still owes its MUL pass before moving to the next bit.
            if (state == MUL || !exponent[ebit]) ebit <= ebit - 1'b1;
          end
        end
        FINISH: begin
          Plain_val  <= r;
          Plain_done <= 1'b1;
          Busy       <= 1'b0;
        end
`ifdef RSA_DEC_MODCHECK_EN
        ERR: begin
          Plain_val  <= '0;
          Plain_done <= 1'b1;
          err_q      <= 1'b1;
          Busy       <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rsa_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_decrypt
// Purpose  : Self-checking bench for rsa_decrypt. It runs table vectors,
//            randomized operands checked against a plain-arithmetic modexp
//            model, a mid-operation restart, a mid-operation reset and, when
//            RSA_DEC_MODCHECK_EN is defined, the zero-modulus error path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_decrypt;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [15:0] Cipher_val, Exp_key, Mod_key, Plain_val;
  logic        Plain_done, Busy, Err;

  always #5 Clk = ~Clk;

  rsa_decrypt #(.WIDTH(16)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Cipher_val (Cipher_val),
    .Exp_key    (Exp_key),
    .Mod_key    (Mod_key),
    .Plain_val  (Plain_val),
    .Plain_done (Plain_done),
    .Busy       (Busy),
    .Err        (Err)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] c;
    logic [15:0] d;
    logic [15:0] n;
    logic [15:0] expv;
    int          lat;
  } vec_t;

  vec_t tab[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Right-to-left binary exponentiation in plain integer arithmetic.
  function automatic logic [15:0] model(input logic [15:0] c, input logic [15:0] d,
                                        input logic [15:0] n);
    longint b, res, e;
    if (n == 16'd1) return 16'd0;
    res = 1;
    b   = longint'(c) % longint'(n);
    e   = longint'(d);
    while (e > 0) begin
      if (e % 2 == 1) res = (res * b) % longint'(n);
      b = (b * b) % longint'(n);
      e = e / 2;
    end
    return 16'(res);
  endfunction

  // One full operation: Start, wait for Plain_done with a bound, check the
  // result, latency, Busy, Err and that no further done pulse follows.
  // restart_at > 0 re-pulses Start with different inputs that many cycles in.
  task automatic run_op(input logic [15:0] c, input logic [15:0] d, input logic [15:0] n,
                        input logic [15:0] expv, input int explat, input int restart_at,
                        input string tag);
    int cyc;
    int extra;
    bit seen;
    bit busy_ok;
    @(negedge Clk);
    Cipher_val = c; Exp_key = d; Mod_key = n; Start = 1'b1;
    @(posedge Clk); #1;
    Start   = 1'b0;
    busy_ok = Busy;
    seen    = 1'b0;
    cyc     = 0;
    for (int i = 1; i <= 700; i++) begin
      if (i == restart_at) begin
        Start = 1'b1; Cipher_val = ~c; Exp_key = d ^ 16'h5a5a; Mod_key = n + 16'd7;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk); #1;
      if (Plain_done) begin
        seen = 1'b1;
        cyc  = i;
        break;
      end
      if (!Busy) busy_ok = 1'b0;
    end
    Start = 1'b0;
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(explat));
    chk({tag, " plain_val"}, 64'(Plain_val), 64'(expv));
    chk({tag, " busy_during_op"}, 64'(busy_ok), 64'd1);
    chk({tag, " busy_after_done"}, 64'(Busy), 64'd0);
    chk({tag, " err"}, 64'(Err), 64'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      if (Plain_done) extra++;
    end
    chk({tag, " extra_done_pulses"}, 64'(extra), 64'd0);
    chk({tag, " plain_val_held"}, 64'(Plain_val), 64'(expv));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rc, rd, rn;
    int          lat_r;
    bit          done_seen;

    tab[0] = '{c: 16'd3,    d: 16'd7,    n: 16'd33,   expv: 16'd9,  lat: 321};
    tab[1] = '{c: 16'd2790, d: 16'd2753, n: 16'd3233, expv: 16'd65, lat: 353};
    tab[2] = '{c: 16'd100,  d: 16'd1,    n: 16'd33,   expv: 16'd1,  lat: 289};
    tab[3] = '{c: 16'd5,    d: 16'd0,    n: 16'd33,   expv: 16'd1,  lat: 273};
    tab[4] = '{c: 16'd5,    d: 16'd3,    n: 16'd1,    expv: 16'd0,  lat: 305};

    Reset = 1'b1; Start = 1'b0;
    Cipher_val = '0; Exp_key = '0; Mod_key = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset plain_val", 64'(Plain_val), 64'd0);
    chk("reset plain_done", 64'(Plain_done), 64'd0);
    chk("reset busy", 64'(Busy), 64'd0);
    chk("reset err", 64'(Err), 64'd0);
    Reset = 1'b0;

    foreach (tab[i])
      run_op(tab[i].c, tab[i].d, tab[i].n, tab[i].expv, tab[i].lat, 0,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      rn = 16'($urandom_range(65535, 2));
      rc = 16'($urandom);
      rd = 16'($urandom);
      lat_r = 17 + 256 + 16 * $countones(rd);
      run_op(rc, rd, rn, model(rc, rd, rn), lat_r, 0, $sformatf("rand%0d", i));
    end

    // Start re-pulsed mid-operation with different inputs.
    run_op(16'd2790, 16'd2753, 16'd3233, 16'd65, 353, 50, "restart");

    // Reset at cycle 100 of an operation, then an immediate new Start.
    @(negedge Clk);
    Cipher_val = 16'd2790; Exp_key = 16'd2753; Mod_key = 16'd3233; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    done_seen = 1'b0;
    for (int i = 1; i < 100; i++) begin
      @(posedge Clk); #1;
      if (Plain_done) done_seen = 1'b1;
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    if (Plain_done) done_seen = 1'b1;
    chk("midreset no_done", 64'(done_seen), 64'd0);
    chk("midreset plain_val", 64'(Plain_val), 64'd0);
    chk("midreset busy", 64'(Busy), 64'd0);
    chk("midreset err", 64'(Err), 64'd0);
    Reset = 1'b0;
    run_op(16'd3, 16'd7, 16'd33, 16'd9, 321, 0, "after_reset");

`ifdef RSA_DEC_MODCHECK_EN
    @(negedge Clk);
    Cipher_val = 16'd5; Exp_key = 16'd3; Mod_key = 16'd0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    chk("modcheck err", 64'(Err), 64'd1);
    chk("modcheck done", 64'(Plain_done), 64'd1);
    chk("modcheck plain_val", 64'(Plain_val), 64'd0);
    chk("modcheck busy", 64'(Busy), 64'd0);
    @(posedge Clk); #1;
    chk("modcheck err_pulse", 64'(Err), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
